// File: rtl/approx_err_accum_if.sv
// Sample stream, control and result bundle for the approximate-multiplier error accumulator.
// The producer/readout side uses master; the accumulator uses slave.
interface approx_err_accum_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [2*WIDTH-1:0]     approx_prod;
  logic                   busy;
  logic                   done;
  logic [15:0]            sample_cnt;
  logic [15:0]            err_count;
  logic [2*WIDTH+15:0]    ed_sum;
  logic [2*WIDTH-1:0]     ed_max;

  modport master (
    output start, in_valid, in_a, in_b, approx_prod,
    input  in_ready, busy, done, sample_cnt, err_count, ed_sum, ed_max
  );

  modport slave (
    input  start, in_valid, in_a, in_b, approx_prod,
    output in_ready, busy, done, sample_cnt, err_count, ed_sum, ed_max
  );
endinterface

// File: rtl/approx_err_accum.sv
// Error statistics over a window of N_SAMPLES approximate products: mismatch count,
// error-distance sum and maximum error distance against the exact unsigned product.
module approx_err_accum #(
  parameter int WIDTH     = 4,
  parameter int N_SAMPLES = 256
) (
  input logic               clk,
  input logic               rst,
  approx_err_accum_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 16;
  localparam logic [15:0] N_LAST = 16'(N_SAMPLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [15:0]            accepted_q;
  logic                   xfer_p0;
  logic                   clear_p0;

  logic                   vld_p1;
  logic [WIDTH-1:0]       a_p1;
  logic [WIDTH-1:0]       b_p1;
  logic [PW-1:0]          approx_p1;

  logic [PW-1:0]          exact_p2;
  logic [PW-1:0]          ed_p2;

  logic [15:0]            sample_cnt_q;
  logic [15:0]            err_count_q;
  logic [SW-1:0]          ed_sum_q;
  logic [PW-1:0]          ed_max_q;

  // Magnitude of the difference, taken in one extra signed bit so approx > exact never wraps.
  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic signed [PW:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    return (d < 0) ? PW'(-d) : PW'(d);
  endfunction

  function automatic logic [PW-1:0] max_sel(input logic [PW-1:0] cur, input logic [PW-1:0] cand);
    return (cand > cur) ? cand : cur;
  endfunction

  // ---- p0: handshake / window start
  assign bus.in_ready = (state_q == RUN) && (accepted_q < N_LAST);
  assign xfer_p0      = bus.in_valid && bus.in_ready;
  assign clear_p0     = bus.start && (state_q != RUN);

  // ---- p2: exact product and error distance from the registered sample
  assign exact_p2 = PW'(a_p1) * PW'(b_p1);
  assign ed_p2    = abs_diff(exact_p2, approx_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_q   <= '0;
      vld_p1       <= 1'b0;
      a_p1         <= '0;
      b_p1         <= '0;
      approx_p1    <= '0;
      sample_cnt_q <= '0;
      err_count_q  <= '0;
      ed_sum_q     <= '0;
      ed_max_q     <= '0;
    end else if (clear_p0) begin
      accepted_q   <= '0;
      vld_p1       <= 1'b0;
      sample_cnt_q <= '0;
      err_count_q  <= '0;
      ed_sum_q     <= '0;
      ed_max_q     <= '0;
    end else begin
      // ---- p1: capture accepted sample
      vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        accepted_q <= accepted_q + 16'd1;
        a_p1       <= bus.in_a;
        b_p1       <= bus.in_b;
        approx_p1  <= bus.approx_prod;
      end
      // ---- p2: accumulate
      if (vld_p1) begin
        sample_cnt_q <= sample_cnt_q + 16'd1;
        err_count_q  <= err_count_q + {15'd0, (ed_p2 != '0)};
        ed_sum_q     <= ed_sum_q + SW'(ed_p2);
        ed_max_q     <= max_sel(ed_max_q, ed_p2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (sample_cnt_q == N_LAST) state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.sample_cnt = sample_cnt_q;
  assign bus.err_count  = err_count_q;
  assign bus.ed_sum     = ed_sum_q;
  assign bus.ed_max     = ed_max_q;

endmodule

// File: tb/tb_approx_err_accum.sv
// Directed bench for approx_err_accum: three instances (N_SAMPLES 4, 2, 3) sharing clk/rst.
module tb_approx_err_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_err_accum_if #(.WIDTH(4)) if4 ();
  approx_err_accum_if #(.WIDTH(4)) if2 ();
  approx_err_accum_if #(.WIDTH(4)) if3 ();

  approx_err_accum #(.WIDTH(4), .N_SAMPLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  approx_err_accum #(.WIDTH(4), .N_SAMPLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  approx_err_accum #(.WIDTH(4), .N_SAMPLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [7:0]  approx;
    logic [15:0] cnt;
    logic [15:0] errs;
    logic [23:0] sum;
    logic [7:0]  max;
  } vec_t;

  vec_t vec [8];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4_results(input string tag, input logic [15:0] c, input logic [15:0] e,
                              input logic [23:0] s, input logic [7:0] m);
    chk({tag, ".sample_cnt"}, 32'(if4.sample_cnt), 32'(c));
    chk({tag, ".err_count"},  32'(if4.err_count),  32'(e));
    chk({tag, ".ed_sum"},     32'(if4.ed_sum),     32'(s));
    chk({tag, ".ed_max"},     32'(if4.ed_max),     32'(m));
  endtask

  initial begin
    // window A: four exact 3*5 samples; window B: mixed errors incl. approx > exact
    vec[0] = '{4'd3,  4'd5,  8'd15,  16'd1, 16'd0, 24'd0,  8'd0};
    vec[1] = '{4'd3,  4'd5,  8'd15,  16'd2, 16'd0, 24'd0,  8'd0};
    vec[2] = '{4'd3,  4'd5,  8'd15,  16'd3, 16'd0, 24'd0,  8'd0};
    vec[3] = '{4'd3,  4'd5,  8'd15,  16'd4, 16'd0, 24'd0,  8'd0};
    vec[4] = '{4'd2,  4'd3,  8'd9,   16'd1, 16'd1, 24'd3,  8'd3};
    vec[5] = '{4'd15, 4'd15, 8'd200, 16'd2, 16'd2, 24'd28, 8'd25};
    vec[6] = '{4'd7,  4'd6,  8'd44,  16'd3, 16'd3, 24'd30, 8'd25};
    vec[7] = '{4'd0,  4'd0,  8'd0,   16'd4, 16'd3, 24'd30, 8'd25};

    rst = 1'b1;
    {if4.start, if4.in_valid, if4.in_a, if4.in_b, if4.approx_prod} = '0;
    {if2.start, if2.in_valid, if2.in_a, if2.in_b, if2.approx_prod} = '0;
    {if3.start, if3.in_valid, if3.in_a, if3.in_b, if3.approx_prod} = '0;
    step(); step();
    rst = 1'b0;
    step();

    chk("rst.busy",     32'(if4.busy),     32'd0);
    chk("rst.done",     32'(if4.done),     32'd0);
    chk("rst.in_ready", 32'(if4.in_ready), 32'd0);
    chk4_results("rst", 16'd0, 16'd0, 24'd0, 8'd0);

    // table-driven windows on the N=4 instance, one gap cycle after each sample
    for (int w = 0; w < 2; w++) begin
      if4.start = 1'b1;
      step();
      if4.start = 1'b0;
      chk("win.busy",     32'(if4.busy),     32'd1);
      chk("win.done",     32'(if4.done),     32'd0);
      chk("win.in_ready", 32'(if4.in_ready), 32'd1);
      chk4_results("win.clear", 16'd0, 16'd0, 24'd0, 8'd0);
      for (int i = w * 4; i < w * 4 + 4; i++) begin
        if4.in_valid = 1'b1;
        if4.in_a = vec[i].a;
        if4.in_b = vec[i].b;
        if4.approx_prod = vec[i].approx;
        step();
        if4.in_valid = 1'b0;
        step();
        chk4_results($sformatf("vec%0d", i), vec[i].cnt, vec[i].errs, vec[i].sum, vec[i].max);
        if (i == 5) begin
          // start while running must not disturb the window
          if4.start = 1'b1;
          step();
          if4.start = 1'b0;
          chk("run_start.busy", 32'(if4.busy), 32'd1);
          chk4_results("run_start", vec[i].cnt, vec[i].errs, vec[i].sum, vec[i].max);
        end
      end
      chk("end.in_ready", 32'(if4.in_ready), 32'd0);
      chk("end.done_early", 32'(if4.done), 32'd0);
      step();
      chk("end.done", 32'(if4.done), 32'd1);
      chk("end.busy", 32'(if4.busy), 32'd0);
      // results hold in DONE even with in_valid asserted
      if4.in_valid = 1'b1;
      step(); step();
      if4.in_valid = 1'b0;
      chk("hold.in_ready", 32'(if4.in_ready), 32'd0);
      chk4_results("hold", vec[w*4+3].cnt, vec[w*4+3].errs, vec[w*4+3].sum, vec[w*4+3].max);
    end

    // reset mid-window, then a fresh back-to-back window
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    if4.in_valid = 1'b1; if4.in_a = 4'd9; if4.in_b = 4'd9; if4.approx_prod = 8'd0;
    step(); step();
    if4.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst.busy", 32'(if4.busy), 32'd0);
    chk("mid_rst.done", 32'(if4.done), 32'd0);
    chk("mid_rst.in_ready", 32'(if4.in_ready), 32'd0);
    chk4_results("mid_rst", 16'd0, 16'd0, 24'd0, 8'd0);

    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    if4.in_valid = 1'b1;
    if4.in_a = 4'd4;  if4.in_b = 4'd4; if4.approx_prod = 8'd16; step();
    if4.in_a = 4'd5;  if4.in_b = 4'd5; if4.approx_prod = 8'd20; step();
    if4.in_a = 4'd3;  if4.in_b = 4'd3; if4.approx_prod = 8'd9;  step();
    if4.in_a = 4'd15; if4.in_b = 4'd1; if4.approx_prod = 8'd14; step();
    if4.in_valid = 1'b0;
    step();
    chk4_results("fresh", 16'd4, 16'd2, 24'd6, 8'd5);
    chk("fresh.done_early", 32'(if4.done), 32'd0);
    step();
    chk("fresh.done", 32'(if4.done), 32'd1);

    // N=2 instance: large errors
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    if2.in_valid = 1'b1;
    if2.in_a = 4'd15; if2.in_b = 4'd15; if2.approx_prod = 8'd200; step();
    if2.in_a = 4'd7;  if2.in_b = 4'd6;  if2.approx_prod = 8'd44;  step();
    if2.in_valid = 1'b0;
    chk("n2.first_ed_sum", 32'(if2.ed_sum), 32'd25);
    chk("n2.first_ed_max", 32'(if2.ed_max), 32'd25);
    step();
    chk("n2.err_count",  32'(if2.err_count),  32'd2);
    chk("n2.ed_sum",     32'(if2.ed_sum),     32'd27);
    chk("n2.ed_max",     32'(if2.ed_max),     32'd25);
    chk("n2.sample_cnt", 32'(if2.sample_cnt), 32'd2);
    step();
    chk("n2.done", 32'(if2.done), 32'd1);

    // N=3 instance: in_valid toggling, extra valids past the window ignored
    begin
      int acc;
      acc = 0;
      if3.start = 1'b1;
      step();
      if3.start = 1'b0;
      if3.in_a = 4'd1; if3.in_b = 4'd2; if3.approx_prod = 8'd3;
      for (int c = 0; c < 12; c++) begin
        if3.in_valid = (c % 2 == 0);
        if (if3.in_valid && if3.in_ready) acc++;
        step();
      end
      if3.in_valid = 1'b0;
      chk("n3.accepts",    32'(acc),            32'd3);
      chk("n3.in_ready",   32'(if3.in_ready),   32'd0);
      chk("n3.sample_cnt", 32'(if3.sample_cnt), 32'd3);
      chk("n3.err_count",  32'(if3.err_count),  32'd3);
      chk("n3.ed_sum",     32'(if3.ed_sum),     32'd3);
      chk("n3.done",       32'(if3.done),       32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
